// File: rtl/fibo_controller.sv
// Moore controller that sequences a 4-register Fibonacci datapath to compute F(N) mod 2^size.
// R0/R1 hold the Fibonacci pair, R2 holds the constant 1 and R3 counts the remaining iterations.
module fibo_controller #(
    parameter int              size    = 4,
    parameter logic [size-2:0] OP_ADD  = 3'b000,
    parameter logic [size-2:0] OP_SUB  = 3'b001,
    parameter logic [size-2:0] OP_PASS = 3'b010
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            start,
    input  logic [size-1:0] n_in,
    input  logic            zero_flag,
    output logic [1:0]      wrt_addr,
    output logic            wrt_en,
    output logic            load_data,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [size-2:0] alu_opcode,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            done
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LD_N   = 4'd1,
        LD_A   = 4'd2,
        LD_B   = 4'd3,
        LD_ONE = 4'd4,
        CHK    = 4'd5,
        ADD    = 4'd6,
        WR     = 4'd7,
        DEC    = 4'd8,
        WB     = 4'd9,
        RES    = 4'd10,
        DONE   = 4'd11
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] n_q, n_d;
    logic            old_q, old_d;
    logic            res_sel_q, res_sel_d;
    // Set once a result exists; until then IDLE drives opcode 0 so every output is 0 out of reset.
    logic            hold_q, hold_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            old_q     <= 1'b0;
            res_sel_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            old_q     <= old_d;
            res_sel_q <= res_sel_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        old_d      = old_q;
        res_sel_d  = res_sel_q;
        hold_d     = hold_q;
        wrt_addr   = 2'd0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        rd_addr1   = 2'd0;
        rd_addr2   = 2'd0;
        alu_opcode = '0;
        count      = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                rd_addr1   = {1'b0, res_sel_q};
                rd_addr2   = {1'b0, res_sel_q};
                alu_opcode = hold_q ? OP_PASS : '0;
                if (start) begin
                    state_d = LD_N;
                    n_d     = n_in;
                    old_d   = 1'b0;
                end
            end
            LD_N: begin
                busy      = 1'b1;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = 2'd3;
                count     = n_q;
                state_d   = LD_A;
            end
            LD_A: begin
                busy      = 1'b1;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = 2'd0;
                state_d   = LD_B;
            end
            LD_B: begin
                busy      = 1'b1;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = 2'd1;
                count     = size'(1);
                state_d   = LD_ONE;
            end
            LD_ONE: begin
                busy      = 1'b1;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = 2'd2;
                count     = size'(1);
                state_d   = CHK;
            end
            CHK: begin
                busy       = 1'b1;
                rd_addr1   = 2'd3;
                rd_addr2   = 2'd3;
                alu_opcode = OP_PASS;
                state_d    = zero_flag ? RES : ADD;
            end
            ADD: begin
                busy       = 1'b1;
                rd_addr1   = 2'd0;
                rd_addr2   = 2'd1;
                alu_opcode = OP_ADD;
                state_d    = WR;
            end
            // The sum overwrites the older pair member, which then becomes the newer one.
            WR: begin
                busy     = 1'b1;
                wrt_en   = 1'b1;
                wrt_addr = {1'b0, old_q};
                old_d    = ~old_q;
                state_d  = DEC;
            end
            DEC: begin
                busy       = 1'b1;
                rd_addr1   = 2'd3;
                rd_addr2   = 2'd2;
                alu_opcode = OP_SUB;
                state_d    = WB;
            end
            WB: begin
                busy     = 1'b1;
                wrt_en   = 1'b1;
                wrt_addr = 2'd3;
                state_d  = CHK;
            end
            RES: begin
                busy       = 1'b1;
                rd_addr1   = {1'b0, old_q};
                rd_addr2   = {1'b0, old_q};
                alu_opcode = OP_PASS;
                res_sel_d  = old_q;
                hold_d     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                done       = 1'b1;
                rd_addr1   = {1'b0, res_sel_q};
                rd_addr2   = {1'b0, res_sel_q};
                alu_opcode = OP_PASS;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
